// File: rtl/fnd_scan_controller.sv
// Scan controller for the 4-digit FND: double-buffered BCD word, blank/show slots per digit, frame-aligned updates.
// All outputs registered. Define FND_LEADING_ZERO_BLANK_EN to suppress enable on leading-zero digits.
module fnd_scan_controller #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_run,
  input  logic [15:0] i_bcd,
  input  logic        i_load,
  output logic [1:0]  o_digitSelect,
  output logic [3:0]  o_value,
  output logic        o_en,
  output logic        o_frameStart,
  output logic        o_loadAck
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t        state, state_nxt;
  logic [15:0]   active, active_nxt;
  logic [15:0]   pending, pending_nxt;
  logic          pend_valid, pend_valid_nxt;
  logic [1:0]    digit, digit_nxt;
  logic [CW-1:0] slot_cnt, slot_cnt_nxt;
  logic          frame_start_nxt;
  logic          load_ack_nxt;
  logic          boundary;
  logic          apply;
  logic          digit_lit;

  always_comb begin
    boundary = (state == SHOW) && (digit == 2'd3) && (slot_cnt == DIGIT_LAST);
    apply    = boundary || (state == IDLE);

    active_nxt     = active;
    pending_nxt    = pending;
    pend_valid_nxt = pend_valid;
    load_ack_nxt   = 1'b0;
    // A load landing on the apply edge goes straight to active, superseding any pending value.
    if (apply) begin
      if (i_load) begin
        active_nxt     = i_bcd;
        pend_valid_nxt = 1'b0;
        load_ack_nxt   = 1'b1;
      end else if (pend_valid) begin
        active_nxt     = pending;
        pend_valid_nxt = 1'b0;
        load_ack_nxt   = 1'b1;
      end
    end else if (i_load) begin
      pending_nxt    = i_bcd;
      pend_valid_nxt = 1'b1;
    end

    state_nxt       = state;
    digit_nxt       = digit;
    slot_cnt_nxt    = slot_cnt + CW'(1);
    frame_start_nxt = 1'b0;
    if (!i_run) begin
      state_nxt    = IDLE;
      digit_nxt    = 2'd0;
      slot_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt       = BLANK;
          digit_nxt       = 2'd0;
          slot_cnt_nxt    = '0;
          frame_start_nxt = 1'b1;
        end
        BLANK: begin
          if (slot_cnt == BLANK_LAST) state_nxt = SHOW;
        end
        SHOW: begin
          if (slot_cnt == DIGIT_LAST) begin
            state_nxt       = BLANK;
            slot_cnt_nxt    = '0;
            digit_nxt       = digit + 2'd1;
            frame_start_nxt = (digit == 2'd3);
          end
        end
        default: begin
          state_nxt    = IDLE;
          digit_nxt    = 2'd0;
          slot_cnt_nxt = '0;
        end
      endcase
    end
  end

`ifdef FND_LEADING_ZERO_BLANK_EN
  // Digit k stays dark while it and every more-significant nibble are zero; digit 0 always lit.
  always_comb begin
    digit_lit = 1'b1;
    case (digit_nxt)
      2'd1:    digit_lit = |active_nxt[15:4];
      2'd2:    digit_lit = |active_nxt[15:8];
      2'd3:    digit_lit = |active_nxt[15:12];
      default: digit_lit = 1'b1;
    endcase
  end
`else
  assign digit_lit = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      active        <= '0;
      pending       <= '0;
      pend_valid    <= 1'b0;
      digit         <= 2'd0;
      slot_cnt      <= '0;
      o_digitSelect <= 2'd0;
      o_value       <= 4'd0;
      o_en          <= 1'b0;
      o_frameStart  <= 1'b0;
      o_loadAck     <= 1'b0;
    end else begin
      state         <= state_nxt;
      active        <= active_nxt;
      pending       <= pending_nxt;
      pend_valid    <= pend_valid_nxt;
      digit         <= digit_nxt;
      slot_cnt      <= slot_cnt_nxt;
      o_digitSelect <= (state_nxt == IDLE) ? 2'd0 : digit_nxt;
      o_value       <= (state_nxt == IDLE) ? 4'd0 : active_nxt[{digit_nxt, 2'b00} +: 4];
      o_en          <= (state_nxt == SHOW) && digit_lit;
      o_frameStart  <= frame_start_nxt;
      o_loadAck     <= load_ack_nxt;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: constant vector table, directed corner sequences and a random run
// checked every cycle against a frame-position reference model.
module tb_fnd_scan_controller;

  localparam int DC = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * DC;
`ifdef FND_LEADING_ZERO_BLANK_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, run, load;
  logic [15:0] bcd;
  logic [1:0]  sel;
  logic [3:0]  val;
  logic        en, fs, ack;

  int checks = 0;
  int failures = 0;

  // Reference model: position inside the frame as a plain cycle index.
  bit          m_running;
  int          m_t;
  logic [15:0] m_active, m_pend;
  bit          m_pvalid;
  logic [8:0]  m_exp;

  fnd_scan_controller #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .i_clk(clk), .i_reset(reset), .i_run(run), .i_bcd(bcd), .i_load(load),
    .o_digitSelect(sel), .o_value(val), .o_en(en), .o_frameStart(fs), .o_loadAck(ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic rn, input logic ld, input logic [15:0] b);
    bit a_ack, apply, lit;
    int d, pos;
    if (r) begin
      m_running = 0; m_t = 0; m_active = 0; m_pend = 0; m_pvalid = 0; m_exp = '0;
      return;
    end
    a_ack = 0;
    apply = !m_running || (m_t == FRAME - 1);
    if (apply && ld) begin
      m_active = b; m_pvalid = 0; a_ack = 1;
    end else if (apply && m_pvalid) begin
      m_active = m_pend; m_pvalid = 0; a_ack = 1;
    end else if (!apply && ld) begin
      m_pend = b; m_pvalid = 1;
    end
    if (!rn) begin
      m_running = 0; m_t = 0;
      m_exp = {8'd0, a_ack};
    end else begin
      if (!m_running) begin
        m_running = 1; m_t = 0;
      end else begin
        m_t = (m_t + 1) % FRAME;
      end
      d   = m_t / DC;
      pos = m_t % DC;
      lit = (d == 0) || ((m_active >> (4 * d)) != 16'd0) || !LZ_EN;
      m_exp = {2'(d), m_active[4*d +: 4], (pos >= BC) && lit, m_t == 0, a_ack};
    end
  endtask

  task automatic step(input logic r, input logic rn, input logic ld, input logic [15:0] b);
    reset = r; run = rn; load = ld; bcd = b;
    @(posedge clk);
    model_step(r, rn, ld, b);
    #1;
    check("model", {23'd0, sel, val, en, fs, ack}, {23'd0, m_exp});
  endtask

  task automatic lz_frame(input logic [15:0] v, input int e0, input int e1, input int e2, input int e3);
    int cnt[4];
    cnt = '{0, 0, 0, 0};
    step(0, 0, 0, 16'h0);
    step(0, 0, 1, v);
    step(0, 1, 0, 16'h0);
    for (int i = 0; i < FRAME; i++) begin
      if (en) cnt[sel]++;
      if (i < FRAME - 1) step(0, 1, 0, 16'h0);
    end
    check("en_cnt_d0", cnt[0], e0);
    check("en_cnt_d1", cnt[1], e1);
    check("en_cnt_d2", cnt[2], e2);
    check("en_cnt_d3", cnt[3], e3);
  endtask

  typedef struct {
    logic        r, rn, ld;
    logic [15:0] b;
    int          n;
    logic [8:0]  exp;   // {sel, val, en, frameStart, loadAck}
  } vec_t;

  vec_t tbl[13];
  int   acks, nonzero, fs_gap, last_fs;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1, {2'd0, 4'h0, 1'b0, 1'b0, 1'b0}};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 16'h1234, 1, {2'd0, 4'h0, 1'b0, 1'b0, 1'b0}};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 16'h1234, 1, {2'd0, 4'h4, 1'b0, 1'b1, 1'b1}};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1, {2'd0, 4'h4, 1'b0, 1'b0, 1'b0}};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1, {2'd0, 4'h4, 1'b1, 1'b0, 1'b0}};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 5, {2'd0, 4'h4, 1'b1, 1'b0, 1'b0}};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1, {2'd1, 4'h3, 1'b0, 1'b0, 1'b0}};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 9, {2'd2, 4'h2, 1'b0, 1'b0, 1'b0}};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 8, {2'd3, 4'h1, 1'b0, 1'b0, 1'b0}};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 7, {2'd0, 4'h4, 1'b0, 1'b1, 1'b0}};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1, {2'd0, 4'h0, 1'b0, 1'b0, 1'b0}};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 16'h0ABC, 1, {2'd0, 4'h0, 1'b0, 1'b0, 1'b1}};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1, {2'd0, 4'hC, 1'b0, 1'b1, 1'b0}};

    reset = 1'b1; run = 1'b0; load = 1'b0; bcd = 16'h0;
    m_running = 0; m_t = 0; m_active = 0; m_pend = 0; m_pvalid = 0; m_exp = '0;

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].r, tbl[i].rn, tbl[i].ld, tbl[i].b);
      check($sformatf("vec%0d", i), {23'd0, sel, val, en, fs, ack}, {23'd0, tbl[i].exp});
    end

    // Load during digit 1 is held until the frame boundary.
    repeat (10) step(0, 1, 0, 16'h0);
    step(0, 1, 1, 16'h5678);
    acks = 0;
    repeat (20) begin step(0, 1, 0, 16'h0); acks += ack; end
    check("hold_sel", sel, 2'd3);
    check("hold_val", val, 4'h0);
    check("no_early_ack", acks, 0);
    step(0, 1, 0, 16'h0);
    check("boundary_apply", {ack, fs, val}, {1'b1, 1'b1, 4'h8});

    // Two loads in one frame collapse into a single ack.
    repeat (3) step(0, 1, 0, 16'h0);
    step(0, 1, 1, 16'hAAAA);
    repeat (5) step(0, 1, 0, 16'h0);
    step(0, 1, 1, 16'h0009);
    acks = 0;
    repeat (22) begin step(0, 1, 0, 16'h0); acks += ack; end
    check("single_ack", acks, 1);
    check("double_load_val", val, 4'h9);
    acks = 0;
    fs_gap = 0; last_fs = 0;
    for (int i = 1; i < FRAME; i++) begin
      step(0, 1, 0, 16'h0);
      acks += ack;
      if (i == DC + BC) check("d1_val", val, 4'h0);
    end
    check("no_extra_ack", acks, 0);

    // Load on the boundary cycle applies on that very edge; frameStart period is one frame.
    step(0, 1, 1, 16'h4321);
    check("bypass_apply", {ack, fs, val}, {1'b1, 1'b1, 4'h1});
    for (int i = 1; i <= FRAME; i++) begin
      step(0, 1, 0, 16'h0);
      if (fs) fs_gap = i;
    end
    check("fs_period", fs_gap, FRAME);

    // Run dropped in digit 2 SHOW, then re-raised.
    repeat (20) step(0, 1, 0, 16'h0);
    check("d2_show", {sel, en}, {2'd2, 1'b1});
    step(0, 0, 0, 16'h0);
    check("run_drop", {sel, val, en, fs, ack}, 9'd0);
    step(0, 1, 0, 16'h0);
    check("restart", {sel, en, fs}, {2'd0, 1'b0, 1'b1});

    // Reset mid-SHOW with a load pending discards it.
    repeat (5) step(0, 1, 0, 16'h0);
    step(0, 1, 1, 16'h9999);
    step(1, 1, 0, 16'h0);
    check("reset_zero", {sel, val, en, fs, ack}, 9'd0);
    acks = 0; nonzero = 0;
    repeat (3 * FRAME) begin
      step(0, 1, 0, 16'h0);
      acks += ack;
      if (val != 4'h0) nonzero++;
    end
    check("discard_ack", acks, 0);
    check("discard_val", nonzero, 0);

    // Leading-zero blanking.
    if (LZ_EN) begin
      lz_frame(16'h0050, DC - BC, DC - BC, 0, 0);
      lz_frame(16'h0000, DC - BC, 0, 0, 0);
    end else begin
      lz_frame(16'h0050, DC - BC, DC - BC, DC - BC, DC - BC);
      lz_frame(16'h0000, DC - BC, DC - BC, DC - BC, DC - BC);
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic        r, rn, ld;
      logic [15:0] b;
      r  = ($urandom_range(0, 299) == 0);
      rn = ($urandom_range(0, 59) != 0);
      ld = ($urandom_range(0, 15) == 0);
      b  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : (16'($urandom) & 16'h00FF);
      step(r, rn, ld, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
